// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_pkg
//  Description : Shared definitions for the weight-stationary systolic array.
//                Holds the controller state encoding and the end-to-end
//                latency (ROWS+COLS) for the default 4x4 geometry, plus a
//                helper that gives the latency for any geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } sa_state_t;

    localparam int unsigned DEFAULT_ROWS = 4;
    localparam int unsigned DEFAULT_COLS = 4;
    localparam int unsigned LATENCY      = DEFAULT_ROWS + DEFAULT_COLS;

    // Cycles from an activation handshake until its result is registered.
    function automatic int unsigned latency_of(input int unsigned rows,
                                               input int unsigned cols);
        return rows + cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
//  Module      : sa_pe
//  Description : One processing element of the weight-stationary array.
//                Holds a stationary weight, forwards the activation to the
//                right and adds weight*activation to the partial sum coming
//                from above.
//  Ports       : clk, rst_n (sync, active-low), en (pipeline advance),
//                w_load/w_in (weight write), act_in/act_out (activation
//                from left / to right), psum_in/psum_out (partial sum from
//                above / to below).
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_pe
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          w_load,
    input  logic signed [DATA_WIDTH-1:0]  w_in,
    input  logic signed [DATA_WIDTH-1:0]  act_in,
    input  logic signed [ACCUM_WIDTH-1:0] psum_in,
    output logic signed [DATA_WIDTH-1:0]  act_out,
    output logic signed [ACCUM_WIDTH-1:0] psum_out
);

    logic signed [DATA_WIDTH-1:0]   weight;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACCUM_WIDTH-1:0]  product_ext;

    assign product     = weight * act_in;
    assign product_ext = {{(ACCUM_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight   <= '0;
            act_out  <= '0;
            psum_out <= '0;
        end else begin
            // Weight writes only happen with nothing in flight, so they are
            // independent of the pipeline enable.
            if (w_load) begin
                weight <= w_in;
            end
            if (en) begin
                act_out  <= act_in;
                psum_out <= psum_in + product_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_array_v2.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_array_v2
//  Description : ROWS x COLS weight-stationary systolic matrix-vector unit
//                with internal input skew, output de-skew, per-column
//                accumulation over groups closed by act_last, and a global
//                output-backpressure stall.
//  Ports       : clk, rst_n (sync, active-low)
//                w_valid/w_ready/w_row/w_data   - weight row write
//                act_valid/act_ready/act_data/act_last - activation vectors
//                out_valid/out_ready/out_data   - accumulated results
//                busy                           - vectors in flight or output pending
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_v2
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [$clog2(ROWS)-1:0]        w_row,
    input  logic [COLS*DATA_WIDTH-1:0]     w_data,
    input  logic                           act_valid,
    output logic                           act_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]     act_data,
    input  logic                           act_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [COLS*ACCUM_WIDTH-1:0]    out_data,
    output logic                           busy
);

    localparam int LAT   = int'(latency_of(ROWS, COLS));
    localparam int CNT_W = $clog2(LAT + 1);

    sa_state_t        state, state_next;
    logic [ROWS-1:0]  loaded, row_load;
    logic             out_valid_q, en, fire, w_we, exit_fire, busy_int;
    logic [CNT_W-1:0] inflight;
    logic [LAT-1:0]   pipe_v, pipe_last;

    logic signed [DATA_WIDTH-1:0]  act_link  [ROWS][COLS+1];
    logic signed [ACCUM_WIDTH-1:0] psum_link [ROWS+1][COLS];
    logic signed [ACCUM_WIDTH-1:0] col_p     [COLS];

    // A pending result that is not being taken freezes the whole datapath.
    assign en        = !(out_valid_q && !out_ready);
    assign busy_int  = rst_n && ((inflight != '0) || out_valid_q);
    assign act_ready = rst_n && (&loaded) && en &&
                       (((state == IDLE) && !w_valid) || (state == RUN));
    assign w_ready   = rst_n && ((state == IDLE) || (state == LOAD)) && !busy_int;
    assign fire      = act_valid && act_ready;
    assign w_we      = w_valid && w_ready;
    assign exit_fire = en && pipe_v[LAT-1];
    assign out_valid = rst_n && out_valid_q;
    assign busy      = busy_int;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (w_valid) state_next = LOAD;
                     else if (fire) state_next = RUN;
            LOAD:    if (!w_valid) state_next = IDLE;
            RUN:     if ((inflight == '0) && !out_valid_q && !act_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Out-of-range row indices decode to no row and are silently dropped.
    for (genvar i = 0; i < ROWS; i++) begin : g_row_dec
        assign row_load[i] = w_we && (int'(w_row) == i);
    end

    // Valid/last sideband travels alongside the data wavefront; its last
    // stage lines up with the de-skewed column sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loaded    <= '0;
            pipe_v    <= '0;
            pipe_last <= '0;
            inflight  <= '0;
        end else begin
            loaded <= loaded | row_load;
            if (en) begin
                pipe_v    <= {pipe_v[LAT-2:0], fire};
                pipe_last <= {pipe_last[LAT-2:0], fire && act_last};
            end
            case ({fire, exit_fire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // ---------------- input skew: row i delayed i cycles ----------------
    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        logic signed [DATA_WIDTH-1:0] sk [i+1];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) sk[k] <= '0;
            end else if (en) begin
                // Bubbles inject zero activations so idle slots carry zero sums.
                sk[0] <= fire ? act_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= i; k++) sk[k] <= sk[k-1];
            end
        end
        assign act_link[i][0] = sk[i];
    end

    // ---------------- PE grid ----------------
    for (genvar j = 0; j < COLS; j++) begin : g_top
        assign psum_link[0][j] = '0;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe_col
            sa_pe #(
                .DATA_WIDTH  (DATA_WIDTH),
                .ACCUM_WIDTH (ACCUM_WIDTH)
            ) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .w_load   (row_load[i]),
                .w_in     (w_data[j*DATA_WIDTH +: DATA_WIDTH]),
                .act_in   (act_link[i][j]),
                .psum_in  (psum_link[i][j]),
                .act_out  (act_link[i][j+1]),
                .psum_out (psum_link[i+1][j])
            );
        end
    end

    // ---------------- output de-skew: column j delayed COLS-1-j ----------------
    for (genvar j = 0; j < COLS; j++) begin : g_deskew
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_direct
            assign col_p[j] = psum_link[ROWS][j];
        end else begin : g_delay
            logic signed [ACCUM_WIDTH-1:0] dl [D];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) dl[k] <= '0;
                end else if (en) begin
                    dl[0] <= psum_link[ROWS][j];
                    for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
                end
            end
            assign col_p[j] = dl[D-1];
        end
    end

    // ---------------- per-column accumulators ----------------
    for (genvar j = 0; j < COLS; j++) begin : g_acc
        logic signed [ACCUM_WIDTH-1:0] acc, sum, lane_q;
        assign sum = acc + col_p[j];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc    <= '0;
                lane_q <= '0;
            end else if (exit_fire) begin
                if (pipe_last[LAT-1]) begin
                    lane_q <= sum;
                    acc    <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
        assign out_data[j*ACCUM_WIDTH +: ACCUM_WIDTH] = lane_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (exit_fire && pipe_last[LAT-1]) begin
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_array_v2
//  Description : Self-checking bench for systolic_array_v2 (4x4, 8-bit data,
//                32-bit accumulators): table of single-vector cases plus
//                sequences for accumulation, stall, weight-write blocking
//                and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_v2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         w_valid, w_ready;
    logic [1:0]   w_row;
    logic [31:0]  w_data;
    logic         act_valid, act_ready, act_last;
    logic [31:0]  act_data;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    logic         busy;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    systolic_array_v2 #(
        .DATA_WIDTH(8), .ROWS(4), .COLS(4), .ACCUM_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .w_data(w_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .act_last(act_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    typedef struct {
        int w[4][4];
        int a[4];
        int y[4];
    } vec_t;

    vec_t tbl[5];
    int   ident[4][4];
    int   ones[4][4];

    task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic signed [31:0] lane(input int j);
        return out_data[j*32 +: 32];
    endfunction

    function automatic logic [31:0] pack4(input int v[4]);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(v[j]);
        return r;
    endfunction

    function automatic logic [31:0] pack_row(input int m[4][4], input int r);
        logic [31:0] p;
        for (int j = 0; j < 4; j++) p[j*8 +: 8] = 8'(m[r][j]);
        return p;
    endfunction

    task automatic write_row(input int r, input logic [31:0] data);
        int n = 0;
        w_valid = 1'b1; w_row = 2'(r); w_data = data;
        #1;
        while (!w_ready && n < 60) begin @(posedge clk); #2; n++; end
        chk("w_ready_wait", (n < 60) ? 1 : 0, 1);
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic load_matrix(input int m[4][4]);
        for (int r = 0; r < 4; r++) write_row(r, pack_row(m, r));
    endtask

    task automatic send_act(input int a[4], input bit last, output int hs);
        int n = 0;
        act_valid = 1'b1; act_last = last; act_data = pack4(a);
        #1;
        while (!act_ready && n < 60) begin @(posedge clk); #2; n++; end
        chk("act_ready_wait", (n < 60) ? 1 : 0, 1);
        @(posedge clk); #1;
        hs = cyc;
        act_valid = 1'b0; act_last = 1'b0;
    endtask

    task automatic wait_out(output bit got);
        int n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        got = out_valid;
    endtask

    task automatic check_lanes(input string nm, input int y[4]);
        for (int j = 0; j < 4; j++) chk($sformatf("%s_y%0d", nm, j), lane(j), y[j]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  hs;
        bit  got;
        bit  bad;
        int  seen_valid, seen_ready;
        logic [127:0] snap;

        rst_n = 1'b0; w_valid = 0; w_row = 0; w_data = 0;
        act_valid = 0; act_data = 0; act_last = 0; out_ready = 1;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ident[i][j]   = (i == j) ? 1 : 0;
                ones[i][j]    = 1;
                tbl[0].w[i][j] = (i == j) ? 1 : 0;
                tbl[1].w[i][j] = -128;
                tbl[2].w[i][j] = i + j;
                tbl[3].w[i][j] = (i == j) ? 2 : -1;
                tbl[4].w[i][j] = 127;
            end
        tbl[0].a = '{1, -2, 3, -4};       tbl[0].y = '{1, -2, 3, -4};
        tbl[1].a = '{-128, -128, -128, -128}; tbl[1].y = '{65536, 65536, 65536, 65536};
        tbl[2].a = '{1, 2, 3, 4};         tbl[2].y = '{20, 30, 40, 50};
        tbl[3].a = '{5, -3, 7, 0};        tbl[3].y = '{6, -18, 12, -9};
        tbl[4].a = '{127, -128, 127, -128}; tbl[4].y = '{-254, -254, -254, -254};

        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_act_ready", act_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w_ready", w_ready, 1);
        chk("rst_out_data_zero", (out_data == '0) ? 1 : 0, 1);

        // Three of four rows loaded: activations must still be refused.
        for (int r = 0; r < 3; r++) write_row(r, pack_row(ident, r));
        @(posedge clk); #1;
        act_valid = 1'b1; #1;
        chk("partial_mask_act_ready", act_ready, 0);
        @(posedge clk); #1;
        act_valid = 1'b0;

        // Table of single-vector groups.
        for (int t = 0; t < 5; t++) begin
            load_matrix(tbl[t].w);
            send_act(tbl[t].a, 1'b1, hs);
            wait_out(got);
            chk($sformatf("t%0d_out_valid", t), got, 1);
            chk($sformatf("t%0d_latency", t), cyc - hs, 8);
            check_lanes($sformatf("t%0d", t), tbl[t].y);
            @(posedge clk); #1;
            chk($sformatf("t%0d_valid_fall", t), out_valid, 0);
        end

        // Back-to-back accumulation, last only on the third vector.
        load_matrix(ones);
        @(posedge clk); #1;
        for (int v = 1; v <= 3; v++) begin
            act_valid = 1'b1; act_data = {4{8'(v)}}; act_last = (v == 3); #1;
            chk($sformatf("b2b_ready%0d", v), act_ready, 1);
            @(posedge clk); #1;
            hs = cyc;
        end
        act_valid = 1'b0; act_last = 1'b0;
        wait_out(got);
        chk("b2b_out_valid", got, 1);
        chk("b2b_latency", cyc - hs, 8);
        check_lanes("b2b", '{24, 24, 24, 24});
        @(posedge clk); #1;
        chk("b2b_single_output", out_valid, 0);
        send_act('{1, 1, 1, 1}, 1'b1, hs);
        wait_out(got);
        check_lanes("acc_cleared", '{4, 4, 4, 4});

        // Output stall for 5 cycles with a second result behind it.
        load_matrix(ident);
        out_ready = 1'b0;
        send_act('{1, 2, 3, 4}, 1'b1, hs);
        send_act('{5, 6, 7, 8}, 1'b1, hs);
        wait_out(got);
        chk("stall_out_valid", got, 1);
        snap = out_data;
        check_lanes("stall_first", '{1, 2, 3, 4});
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d", k), (out_data == snap) ? 1 : 0, 1);
            chk($sformatf("stall_act_ready%0d", k), act_ready, 0);
            chk($sformatf("stall_valid%0d", k), out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        wait_out(got);
        chk("stall_second_valid", got, 1);
        check_lanes("stall_second", '{5, 6, 7, 8});
        @(posedge clk); #1;

        // Weight write attempted while a vector is in flight.
        load_matrix(ones);
        send_act('{1, 1, 1, 1}, 1'b1, hs);
        w_valid = 1'b1; w_row = 2'd0; w_data = {4{8'sd5}};
        #1;
        chk("wblock_w_ready_initial", w_ready, 0);
        bad = 0; got = 0; snap = '0;
        for (int n = 0; n < 40; n++) begin
            if (out_valid) begin got = 1; snap = out_data; end
            if (busy && w_ready) bad = 1;
            if (w_ready) break;
            @(posedge clk); #2;
        end
        chk("wblock_ready_while_busy", bad, 0);
        chk("wblock_ready_eventually", w_ready, 1);
        chk("wblock_old_result_seen", got, 1);
        chk("wblock_old_y0", snap[31:0], 4);
        chk("wblock_old_y3", snap[127:96], 4);
        @(posedge clk); #1;
        w_valid = 1'b0;
        send_act('{1, 1, 1, 1}, 1'b1, hs);
        wait_out(got);
        check_lanes("wblock_new", '{8, 8, 8, 8});
        @(posedge clk); #1;

        // Reset three cycles after a handshake.
        send_act('{1, 1, 1, 1}, 1'b1, hs);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_act_ready", act_ready, 0);
        chk("mid_rst_w_ready", w_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        act_valid = 1'b1; act_last = 1'b1; act_data = {4{8'sd3}};
        seen_valid = 0; seen_ready = 0;
        for (int k = 0; k < 15; k++) begin
            #1;
            if (out_valid) seen_valid++;
            if (act_ready) seen_ready++;
            @(posedge clk); #1;
        end
        act_valid = 1'b0; act_last = 1'b0;
        chk("mid_rst_no_out_valid", seen_valid, 0);
        chk("mid_rst_act_blocked", seen_ready, 0);
        chk("mid_rst_busy_after", busy, 0);
        load_matrix(ident);
        send_act('{7, -8, 9, -10}, 1'b1, hs);
        wait_out(got);
        chk("reload_out_valid", got, 1);
        chk("reload_latency", cyc - hs, 8);
        check_lanes("reload", '{7, -8, 9, -10});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_array_v2.md
SYSTOLIC_ARRAY_V2 -- requirements
Module: systolic_array_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed activation/weight width.
REQ-002 SHALL have parameter ROWS, default 4: PE rows (activation lanes), range 2..32.
REQ-003 SHALL have parameter COLS, default 4: PE columns (output lanes), range 2..32.
REQ-004 SHALL have parameter ACCUM_WIDTH, default 32: signed partial-sum/accumulator width, at least 2*DATA_WIDTH+clog2(ROWS).
REQ-005 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, synchronous, active-low reset).
REQ-006 SHALL have ports w_valid (in, 1), w_ready (out, 1), w_row (in, clog2(ROWS), row index) and w_data (in, COLS*DATA_WIDTH, lane j = weight[w_row][j]).
REQ-007 SHALL have ports act_valid (in, 1), act_ready (out, 1), act_data (in, ROWS*DATA_WIDTH, lane i = a[i], unskewed) and act_last (in, 1, closes accumulation group).
REQ-008 SHALL have ports out_valid (out, 1), out_ready (in, 1) and out_data (out, COLS*ACCUM_WIDTH, lane j = y[j]).
REQ-009 SHALL have port busy (out, 1), high while any vector is in flight or an output is pending.

Function
REQ-010 SHALL compute per accepted vector p[j] = sum over i of w[i][j]*a[i], with signed DATA_WIDTH products sign-extended to ACCUM_WIDTH and two's-complement wrap on overflow.
REQ-011 SHALL use a weight-stationary dataflow: activations move right one PE per cycle, partial sums move down one PE per cycle, and input skew (row i delayed i cycles) plus output de-skew (column j delayed COLS-1-j cycles) are internal.
REQ-012 SHALL contain a per-column output accumulator: acc[j] += p[j] per vector; on a vector with act_last=1, out_data is set to acc+p, out_valid rises, and acc clears to 0.
REQ-013 SHALL assert out_valid exactly ROWS+COLS cycles after the accepting handshake of an act_last=1 vector, with no stall in between.
REQ-014 SHALL stall globally: while out_valid=1 and out_ready=0, every pipeline, skew and accumulator register holds and act_ready=0.
REQ-015 SHALL hold out_data stable while out_valid=1 and out_ready=0; out_valid SHALL fall the cycle after out_valid&&out_ready unless a new result lands in that same cycle.
REQ-016 SHALL have FSM states IDLE, LOAD and RUN.
REQ-017 SHALL make these transitions: IDLE->LOAD on w_valid; LOAD->IDLE when w_valid=0; IDLE->RUN on an act handshake; RUN->IDLE when the in-flight count is 0, out_valid=0 and act_valid=0.
REQ-018 SHALL drive w_ready=1 only in IDLE or LOAD with busy=0; a weight write SHALL never occur while vectors are in flight.
REQ-019 SHALL keep a per-row loaded mask and drive act_ready=0 until all ROWS rows have been written since reset; rewriting a row SHALL overwrite it.
REQ-020 SHALL give weight load priority when w_valid and act_valid rise together in IDLE; act_ready=0 in LOAD.
REQ-021 SHALL treat w_row >= ROWS as accepted and ignored (no mask or weight change).
REQ-022 SHALL keep the in-flight counter at 0..ROWS+COLS; it increments on an act handshake, decrements when a vector exits de-skew, and is unchanged on a simultaneous increment and decrement.
REQ-023 SHALL sustain act_ready=1 on back-to-back vectors (one per cycle) in RUN absent a stall.

Reset
REQ-024 SHALL, on rst_n=0 at a clk edge, clear the FSM to IDLE and clear all weights, loaded mask, skew/PE/de-skew registers, accumulators, in-flight counter and out_data to 0.
REQ-025 SHALL hold out_valid, act_ready, w_ready and busy at 0 during reset; mid-operation reset SHALL discard in-flight vectors with no later out_valid for them.

Structure
REQ-026 SHALL place the FSM state encoding and the LATENCY = ROWS+COLS constant in shared package accel_pkg.
REQ-027 SHALL instantiate sub-module sa_pe (one weight register, one activation register, one psum register, MAC, enable input) ROWS*COLS times via generate.

Verification
REQ-028 SHALL cover identity weights (4x4, w[i][j]=1 if i=j), a=(1,-2,3,-4), last=1 -> out_data=(1,-2,3,-4) exactly 8 cycles after handshake.
REQ-029 SHALL cover all weights=-128 and a=all -128 with last=1 -> each y[j]=65536.
REQ-030 SHALL cover three back-to-back vectors a=(1,1,1,1),(2,2,2,2),(3,3,3,3) with w=all 1 and last only on the third -> one output with y[j]=24 and acc cleared afterwards.
REQ-031 SHALL cover out_ready=0 for 5 cycles with out_valid high -> out_data stable, act_ready=0, and the next result correct after release.
REQ-032 SHALL cover w_valid asserted while a vector is in flight -> w_ready=0 until busy=0, and the in-flight result uses the old weights.
REQ-033 SHALL cover rst_n=0 for 1 cycle, 3 cycles after an act handshake -> no out_valid, act_ready=0 until all rows are reloaded.
